// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - GPIO bank: output/direction registers, synchronised inputs, edge events, level irq
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             sel,
    input  logic             wr,
    input  logic             rd,
    input  logic [2:0]       addr,
    input  logic [15:0]      wd,
    output logic [15:0]      rdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_SET  = 3'd2;
    localparam logic [2:0] A_CLR  = 3'd3;
    localparam logic [2:0] A_TGL  = 3'd4;
    localparam logic [2:0] A_RISE = 3'd5;
    localparam logic [2:0] A_FALL = 3'd6;
    localparam logic [2:0] A_EVT  = 3'd7;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] event_q;
    logic [WIDTH-1:0] wd_w;
    logic [WIDTH-1:0] ev_set;
    logic [WIDTH-1:0] ev_clr;
    logic [15:0]      rd_val;
    logic             wr_en;
    logic             rd_en;
    logic             unused_wd;

    assign wd_w      = wd[WIDTH-1:0];
    assign unused_wd = &{1'b0, wd};
    assign wr_en     = sel & wr;
    assign rd_en     = sel & rd;
    assign sync_val  = sync_q[SYNC_STAGES-1];

    assign ev_set = (rise_q & sync_val & ~prev_q) | (fall_q & ~sync_val & prev_q);
    assign ev_clr = (wr_en && addr == A_EVT) ? wd_w : '0;

    assign pin_out = out_q;
    assign pin_oe  = dir_q;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
            prev_q <= sync_val;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            out_q  <= '0;
            dir_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else if (wr_en) begin
            case (addr)
                A_DATA:  out_q  <= wd_w;
                A_DIR:   dir_q  <= wd_w;
                A_SET:   out_q  <= out_q | wd_w;
                A_CLR:   out_q  <= out_q & ~wd_w;
                A_TGL:   out_q  <= out_q ^ wd_w;
                A_RISE:  rise_q <= wd_w;
                A_FALL:  fall_q <= wd_w;
                default: ;
            endcase
        end
    end

    // Clear is applied before set so a same-edge detection keeps the bit.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            event_q <= '0;
            irq     <= 1'b0;
        end else begin
            event_q <= (event_q & ~ev_clr) | ev_set;
            irq     <= |event_q;
        end
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            A_DATA:                rd_val[WIDTH-1:0] = sync_val;
            A_DIR:                 rd_val[WIDTH-1:0] = dir_q;
            A_SET, A_CLR, A_TGL:   rd_val[WIDTH-1:0] = out_q;
            A_RISE:                rd_val[WIDTH-1:0] = rise_q;
            A_FALL:                rd_val[WIDTH-1:0] = fall_q;
            default:               rd_val[WIDTH-1:0] = event_q;
        endcase
    end

    // Idle cycles return zero so several banks can share an OR-ed read bus.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rdata <= '0;
        end else begin
            rdata <= rd_en ? rd_val : 16'h0000;
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - scoreboard bench for gpio_bank at WIDTH=8 and WIDTH=5
module tb_gpio_bank;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetq;
    logic              sel;
    logic              wr;
    logic              rd;
    logic [2:0]        addr;
    logic [15:0]       wd;
    logic [1:0][15:0]  pins;
    logic [15:0]       rdata8;
    logic [15:0]       rdata5;
    logic [7:0]        po8;
    logic [7:0]        oe8;
    logic [4:0]        po5;
    logic [4:0]        oe5;
    logic              irq8;
    logic              irq5;

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut8 (
        .clk(clk), .resetq(resetq), .sel(sel), .wr(wr), .rd(rd), .addr(addr), .wd(wd),
        .rdata(rdata8), .pin_in(pins[0][7:0]), .pin_out(po8), .pin_oe(oe8), .irq(irq8)
    );

    gpio_bank #(.WIDTH(5), .SYNC_STAGES(SYNC)) dut5 (
        .clk(clk), .resetq(resetq), .sel(sel), .wr(wr), .rd(rd), .addr(addr), .wd(wd),
        .rdata(rdata5), .pin_in(pins[1][4:0]), .pin_out(po5), .pin_oe(oe5), .irq(irq5)
    );

    typedef struct packed {
        logic [1:0][15:0] rdata;
        logic [1:0][15:0] po;
        logic [1:0][15:0] oe;
        logic [1:0]       irq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: per-pin register values and a delay line of pad samples.
    logic [15:0] mask   [2];
    logic [15:0] out_m  [2];
    logic [15:0] dir_m  [2];
    logic [15:0] rise_m [2];
    logic [15:0] fall_m [2];
    logic [15:0] ev_m   [2];
    logic [15:0] hist   [2][SYNC+1];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            out_m[k] = '0; dir_m[k] = '0; rise_m[k] = '0; fall_m[k] = '0; ev_m[k] = '0;
            for (int j = 0; j <= SYNC; j++) hist[k][j] = '0;
        end
    endtask

    task automatic tick(input logic s, input logic w, input logic r,
                        input logic [2:0] a, input logic [15:0] d);
        exp_t e;
        sel = s; wr = w; rd = r; addr = a; wd = d;
        for (int k = 0; k < 2; k++) begin
            logic [15:0] sy, pv, setb, rv, dm;
            sy = hist[k][SYNC-1];
            pv = hist[k][SYNC];
            dm = d & mask[k];
            rv = '0;
            if (s && r) begin
                case (a)
                    3'd0:             rv = sy;
                    3'd1:             rv = dir_m[k];
                    3'd2, 3'd3, 3'd4: rv = out_m[k];
                    3'd5:             rv = rise_m[k];
                    3'd6:             rv = fall_m[k];
                    default:          rv = ev_m[k];
                endcase
            end
            e.rdata[k] = rv;
            e.irq[k]   = |ev_m[k];
            setb = (rise_m[k] & sy & ~pv) | (fall_m[k] & ~sy & pv);
            if (s && w) begin
                case (a)
                    3'd0:    out_m[k]  = dm;
                    3'd1:    dir_m[k]  = dm;
                    3'd2:    out_m[k]  = out_m[k] | dm;
                    3'd3:    out_m[k]  = out_m[k] & ~dm;
                    3'd4:    out_m[k]  = out_m[k] ^ dm;
                    3'd5:    rise_m[k] = dm;
                    3'd6:    fall_m[k] = dm;
                    default: ev_m[k]   = ev_m[k] & ~dm;
                endcase
            end
            ev_m[k] = ev_m[k] | setb;
            e.po[k] = out_m[k];
            e.oe[k] = dir_m[k];
            for (int j = SYNC; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = pins[k] & mask[k];
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    endtask

    // Reset lands between edges; outputs must clear before the next clock.
    task automatic reset_pulse();
        exp_t e;
        sel = 1'b0; wr = 1'b0; rd = 1'b0;
        @(posedge clk);
        #2 resetq = 1'b0;
        #1;
        check("rst_po8", {8'h00, po8}, 16'h0000);
        check("rst_irq8", {15'h0, irq8}, 16'h0000);
        check("rst_irq5", {15'h0, irq5}, 16'h0000);
        check("rst_oe8", {8'h00, oe8}, 16'h0000);
        check("rst_rdata8", rdata8, 16'h0000);
        #1 resetq = 1'b1;
        model_reset();
        e = '0;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        logic [1:0][15:0] act_rd, act_po, act_oe;
        logic [1:0]       act_irq;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e       = sb.pop_front();
                act_rd  = {rdata5, rdata8};
                act_po  = {11'h0, po5, 8'h00, po8};
                act_oe  = {11'h0, oe5, 8'h00, oe8};
                act_irq = {irq5, irq8};
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("sb_rdata_w%0d", k == 0 ? 8 : 5), act_rd[k], e.rdata[k]);
                    check($sformatf("sb_pin_out_w%0d", k == 0 ? 8 : 5), act_po[k], e.po[k]);
                    check($sformatf("sb_pin_oe_w%0d", k == 0 ? 8 : 5), act_oe[k], e.oe[k]);
                    check($sformatf("sb_irq_w%0d", k == 0 ? 8 : 5), {15'h0, act_irq[k]}, {15'h0, e.irq[k]});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        mask[0] = 16'h00FF;
        mask[1] = 16'h001F;
        resetq = 1'b0; sel = 1'b0; wr = 1'b0; rd = 1'b0; addr = 3'd0; wd = '0; pins = '0;
        model_reset();
        #3;
        check("init_po8", {8'h00, po8}, 16'h0000);
        check("init_oe5", {11'h0, oe5}, 16'h0000);
        check("init_irq8", {15'h0, irq8}, 16'h0000);
        @(negedge clk);
        #1 resetq = 1'b1;

        idle(2);
        tick(1, 1, 0, 3'd1, 16'h00FF);
        tick(1, 1, 0, 3'd0, 16'h000F);
        tick(1, 1, 0, 3'd2, 16'h0030);
        tick(1, 1, 0, 3'd3, 16'h0001);
        tick(1, 1, 0, 3'd4, 16'h0081);
        check("seq_pin_out8", {8'h00, po8}, 16'h00BF);
        check("seq_pin_oe8", {8'h00, oe8}, 16'h00FF);
        tick(1, 0, 1, 3'd2, 16'h0000);
        check("seq_read_set8", rdata8, 16'h00BF);

        tick(1, 1, 0, 3'd5, 16'h0001);
        idle(3);
        pins[0][0] = 1'b1; pins[1][0] = 1'b1;
        idle(3);
        check("rise_irq_lag", {15'h0, irq8}, 16'h0000);
        tick(1, 0, 1, 3'd7, 16'h0000);
        check("rise_event8", rdata8, 16'h0001);
        check("rise_irq8", {15'h0, irq8}, 16'h0001);
        tick(1, 1, 0, 3'd7, 16'h0001);
        idle(1);
        check("clr_irq8", {15'h0, irq8}, 16'h0000);

        pins[0][2] = 1'b1; pins[1][2] = 1'b1;
        tick(1, 1, 0, 3'd6, 16'h0004);
        idle(4);
        pins[0][2] = 1'b0; pins[1][2] = 1'b0;
        idle(2);
        tick(1, 1, 0, 3'd7, 16'h0004);
        tick(1, 0, 1, 3'd7, 16'h0000);
        check("set_wins8", rdata8 & 16'h0004, 16'h0004);
        check("set_wins5", rdata5 & 16'h0004, 16'h0004);
        tick(1, 1, 0, 3'd7, 16'hFFFF);

        pins[1] = 16'h0015;
        tick(1, 1, 0, 3'd0, 16'hFFFF);
        check("w5_pin_out", {11'h0, po5}, 16'h001F);
        idle(2);
        tick(1, 0, 1, 3'd0, 16'h0000);
        check("w5_read_data", rdata5, 16'h0015);
        idle(1);
        check("w5_rdata_idle", rdata5, 16'h0000);

        for (int a = 0; a < 8; a++) tick(0, 1, 0, 3'(a), 16'(32'h5A5A + a));
        check("nosel_po8", {8'h00, po8}, 16'h00FF);
        check("nosel_oe8", {8'h00, oe8}, 16'h00FF);

        pins = '0;
        tick(1, 1, 0, 3'd0, 16'h00AA);
        tick(1, 1, 0, 3'd5, 16'h0003);
        idle(3);
        pins[0] = 16'h0003; pins[1] = 16'h0003;
        idle(4);
        check("pre_rst_irq8", {15'h0, irq8}, 16'h0001);
        check("pre_rst_po8", {8'h00, po8}, 16'h00AA);
        reset_pulse();
        tick(1, 1, 0, 3'd1, 16'h0055);
        check("post_rst_write", {8'h00, oe8}, 16'h0055);
        tick(1, 0, 1, 3'd7, 16'h0000);
        check("post_rst_event", rdata8, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pins[0] = 16'($urandom);
                pins[1] = 16'($urandom);
            end
            if (i == 200) reset_pulse();
            tick($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                 3'($urandom_range(0, 7)), 16'($urandom));
        end

        idle(2);
        @(negedge clk);
        #1;
        check("sb_drain", 16'(sb.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
